// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and default sizes for the register_file slice.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_default_width = 16;
    localparam int c_default_depth = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_clear_fsm.sv
`default_nettype none
// ============================================================================
// Module      : regfile_clear_fsm
// Description : Clear-all sequencer; walks the bank zeroing one entry per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH  = c_default_depth,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              clr_start,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

    clr_state_e        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;
    logic              r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (clr_req) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Stop on the last real entry so non-power-of-two depths never touch unused codes
                    if (r_cnt == c_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign clr_done  = r_done;
    assign clr_we    = r_busy;
    assign clr_addr  = r_cnt;
    assign clr_start = (r_state == IDLE) && clr_req;

endmodule : regfile_clear_fsm
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : DEPTH x WIDTH register bank, one write port, two registered
//               read ports and a sequenced clear-all engine.
//               Optional macro REGFILE_BYPASS_EN enables write-first forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH  = c_default_width,
    parameter int DEPTH  = c_default_depth,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    localparam int                c_depth_int = DEPTH;
    localparam logic [ADDR_W:0]   c_depth     = c_depth_int[ADDR_W:0];

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [WIDTH-1:0]  r_rdata_a;
    logic [WIDTH-1:0]  r_rdata_b;

    logic              w_busy;
    logic              w_clr_start;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_en;
    logic              w_a_in_range;
    logic              w_b_in_range;
    logic [WIDTH-1:0]  w_next_a;
    logic [WIDTH-1:0]  w_next_b;

    regfile_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .busy      (w_busy),
        .clr_done  (clr_done),
        .clr_start (w_clr_start),
        .clr_we    (w_clr_we),
        .clr_addr  (w_clr_addr)
    );

    // A clear request arriving in the same cycle as a write takes priority
    assign w_wr_en      = we && !w_busy && !w_clr_start && ({1'b0, waddr} < c_depth);
    assign w_a_in_range = ({1'b0, raddr_a} < c_depth);
    assign w_b_in_range = ({1'b0, raddr_b} < c_depth);

    always_comb begin
        w_next_a = '0;
        w_next_b = '0;
        if (w_a_in_range) w_next_a = r_mem[raddr_a];
        if (w_b_in_range) w_next_b = r_mem[raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (waddr == raddr_a)) w_next_a = wdata;
        if (w_wr_en && (waddr == raddr_b)) w_next_b = wdata;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            r_rdata_a <= w_next_a;
            r_rdata_b <= w_next_b;
            if (w_clr_we) begin
                r_mem[w_clr_addr] <= '0;
            end else if (w_wr_en) begin
                r_mem[waddr] <= wdata;
            end
        end
    end

    assign rdata_a = r_rdata_a;
    assign rdata_b = r_rdata_b;
    assign busy    = w_busy;

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Self-checking bench for register_file (DEPTH=8 and DEPTH=6).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic [2:0]  raddr_a = '0;
    logic [2:0]  raddr_b = '0;
    logic        clr_req = 1'b0;
    logic [15:0] rdata_a, rdata_b;
    logic        busy, clr_done;

    logic        we6 = 1'b0;
    logic [2:0]  waddr6 = '0;
    logic [15:0] wdata6 = '0;
    logic [2:0]  ra6a = '0;
    logic [2:0]  ra6b = '0;
    logic        clr6 = 1'b0;
    logic [15:0] rd6a, rd6b;
    logic        busy6, done6;

    register_file dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
    );

    register_file #(.WIDTH(16), .DEPTH(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .we(we6), .waddr(waddr6), .wdata(wdata6),
        .raddr_a(ra6a), .rdata_a(rd6a), .raddr_b(ra6b), .rdata_b(rd6b),
        .clr_req(clr6), .busy(busy6), .clr_done(done6)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: bank contents plus position of the clear walk
    // (-1 idle, 0..D-1 entry being cleared this cycle, D = done pulse).
    logic [15:0] m_mem [D];
    logic [15:0] m_rd_a, m_rd_b;
    int          m_idx = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        m_rd_a = '0;
        m_rd_b = '0;
        m_idx  = -1;
    endtask

    function automatic logic [15:0] mread(input int ra, input logic acc,
                                          input int wa, input logic [15:0] wd);
        logic [15:0] v;
        v = (ra < D) ? m_mem[ra] : 16'h0;
`ifdef REGFILE_BYPASS_EN
        if (acc && wa == ra) v = wd;
`endif
        return v;
    endfunction

    // One clock: update the model from the inputs seen at the edge, then check.
    task automatic cycle();
        logic        acc;
        logic        clearing;
        logic [15:0] na, nb;
        @(posedge clk);
        clearing = (m_idx >= 0) && (m_idx < D);
        acc = we && !clearing && !(m_idx == -1 && clr_req) && (int'(waddr) < D);
        na  = mread(int'(raddr_a), acc, int'(waddr), wdata);
        nb  = mread(int'(raddr_b), acc, int'(waddr), wdata);
        if (acc) m_mem[waddr] = wdata;
        if (m_idx == -1) begin
            if (clr_req) m_idx = 0;
        end else if (m_idx < D) begin
            m_mem[m_idx] = '0;
            m_idx++;
        end else begin
            m_idx = -1;
        end
        m_rd_a = na;
        m_rd_b = nb;
        #1;
        chk("rdata_a", {16'h0, rdata_a}, {16'h0, m_rd_a});
        chk("rdata_b", {16'h0, rdata_b}, {16'h0, m_rd_b});
        chk("busy", {31'h0, busy}, {31'h0, (m_idx >= 0 && m_idx < D)});
        chk("clr_done", {31'h0, clr_done}, {31'h0, (m_idx == D)});
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [2:0] ra, input logic [2:0] rb, input logic cr);
        we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb; clr_req = cr;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fillv [D];
        int busy_cnt, done_at, done_seen;

        // Reset state
        model_reset();
        #12;
        chk("reset_rdata_a", {16'h0, rdata_a}, 32'h0);
        chk("reset_rdata_b", {16'h0, rdata_b}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, clr_done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read
        drive(1'b1, 3'd3, 16'h939A, 3'd0, 3'd0, 1'b0);
        drive(1'b0, 3'd0, 16'h0, 3'd3, 3'd0, 1'b0);
        chk("basic_a", {16'h0, rdata_a}, 32'h939A);
        chk("basic_b", {16'h0, rdata_b}, 32'h0);

        // Dual-port independence
        drive(1'b1, 3'd1, 16'hFFFF, 3'd0, 3'd0, 1'b0);
        drive(1'b1, 3'd6, 16'hCED8, 3'd0, 3'd0, 1'b0);
        drive(1'b0, 3'd0, 16'h0, 3'd6, 3'd1, 1'b0);
        chk("dual_a", {16'h0, rdata_a}, 32'hCED8);
        chk("dual_b", {16'h0, rdata_b}, 32'hFFFF);

        // Read-during-write
        drive(1'b1, 3'd2, 16'h1111, 3'd0, 3'd0, 1'b0);
        drive(1'b1, 3'd2, 16'h2222, 3'd2, 3'd0, 1'b0);
`ifdef REGFILE_BYPASS_EN
        chk("rdw_same_cycle", {16'h0, rdata_a}, 32'h2222);
`else
        chk("rdw_same_cycle", {16'h0, rdata_a}, 32'h1111);
`endif
        drive(1'b0, 3'd0, 16'h0, 3'd2, 3'd0, 1'b0);
        chk("rdw_next_cycle", {16'h0, rdata_a}, 32'h2222);

        // Randomised traffic with occasional clears
        for (int n = 0; n < 250; n++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                  3'($urandom), 3'($urandom), ($urandom_range(0, 24) == 0));
        end
        for (int n = 0; n < 20 && m_idx != -1; n++) drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
        chk("idle_before_clear", m_idx, 32'hFFFF_FFFF);

        // Clear sequence with collisions
        for (int i = 0; i < D; i++) begin
            fillv[i] = 16'h1001 + 16'(i) * 16'h0111;
            drive(1'b1, 3'(i), fillv[i], 3'd0, 3'd0, 1'b0);
        end
        busy_cnt = 0;
        done_at  = 0;
        drive(1'b1, 3'd4, 16'hABCD, 3'd7, 3'd4, 1'b1);
        busy_cnt += busy;
        for (int n = 2; n <= 12; n++) begin
            if (n == 3)      drive(1'b1, 3'd2, 16'h7777, 3'd7, 3'd4, 1'b0);
            else if (n == 5) drive(1'b0, 3'd0, 16'h0, 3'd7, 3'd4, 1'b1);
            else             drive(1'b0, 3'd0, 16'h0, 3'd7, 3'd4, 1'b0);
            busy_cnt += busy;
            if (clr_done && done_at == 0) done_at = n;
            if (n == 4)  chk("mid_clear_old7", {16'h0, rdata_a}, {16'h0, fillv[7]});
            if (n == 10) chk("after_clear7", {16'h0, rdata_a}, 32'h0);
        end
        chk("busy_len", busy_cnt, 8);
        chk("done_cycle", done_at, 9);
        for (int i = 0; i < D; i++) begin
            drive(1'b0, 3'd0, 16'h0, 3'(i), 3'd4, 1'b0);
            drive(1'b0, 3'd0, 16'h0, 3'(i), 3'd4, 1'b0);
            chk("cleared_entry", {16'h0, rdata_a}, 32'h0);
        end
        chk("collide_entry4", {16'h0, rdata_b}, 32'h0);

        // Reset in the middle of a clear
        drive(1'b1, 3'd6, 16'h4444, 3'd6, 3'd6, 1'b0);
        drive(1'b0, 3'd0, 16'h0, 3'd6, 3'd6, 1'b1);
        drive(1'b0, 3'd0, 16'h0, 3'd6, 3'd6, 1'b0);
        drive(1'b0, 3'd0, 16'h0, 3'd6, 3'd6, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_done", {31'h0, clr_done}, 32'h0);
        chk("midrst_rdata_a", {16'h0, rdata_a}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 12; n++) begin
            drive(1'b0, 3'd0, 16'h0, 3'(n % D), 3'd6, 1'b0);
            done_seen += clr_done;
        end
        chk("midrst_no_done", done_seen, 0);
        chk("midrst_entry6", {16'h0, rdata_b}, 32'h0);

        // DEPTH=6 instance: out-of-range write/read and clear length
        we6 = 1'b1; waddr6 = 3'd7; wdata6 = 16'h1234;
        drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
        we6 = 1'b1; waddr6 = 3'd5; wdata6 = 16'h5555;
        drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
        we6 = 1'b0; ra6a = 3'd7; ra6b = 3'd5;
        drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
        chk("d6_oor_read7", {16'h0, rd6a}, 32'h0);
        chk("d6_read5", {16'h0, rd6b}, 32'h5555);
        ra6a = 3'd6;
        drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
        chk("d6_oor_read6", {16'h0, rd6a}, 32'h0);
        clr6 = 1'b1;
        busy_cnt = 0;
        done_at  = 0;
        for (int n = 1; n <= 10; n++) begin
            drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
            clr6 = 1'b0;
            busy_cnt += busy6;
            if (done6 && done_at == 0) done_at = n;
        end
        chk("d6_busy_len", busy_cnt, 6);
        chk("d6_done_cycle", done_at, 7);
        drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
        chk("d6_cleared5", {16'h0, rd6b}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_register_file
`default_nettype wire

// File: doc/register_file.md
Name: register_file

Overview:
- Parametrised successor to the single 16-bit register: a bank of DEPTH registers of WIDTH bits.
- One write port, two independent registered read ports, and a sequenced clear-all engine that zeroes one entry per cycle.
- Sits between the ALU datapath and the control unit as the general-purpose register bank; it also serves as a building block for small RAMs.

Parameters:
- WIDTH, 16, data bits per entry
- DEPTH, 8, number of entries (>=2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- raddr_a  input  ADDR_W  read address, port A
- rdata_a  output  WIDTH  registered read data, port A
- raddr_b  input  ADDR_W  read address, port B
- rdata_b  output  WIDTH  registered read data, port B
- clr_req  input  1  single-cycle request to start clear-all
- busy  output  1  clear sequence in progress
- clr_done  output  1  one-cycle pulse when clear completes

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n=0: all entries, rdata_a, rdata_b, busy, clr_done = 0; FSM = IDLE; clear counter = 0.
  - Reset mid-clear aborts the clear immediately; there is no clr_done pulse.
- Write: at the rising edge with we=1, busy=0 and waddr<DEPTH, entry[waddr] <= wdata. Otherwise no entry changes.
- Read:
  - Latency 1: rdata_x at edge N+1 = entry[raddr_x] as it stood before edge N+1's write.
  - Read-during-write to the same address returns the old value (unless the optional feature is enabled).
  - raddr_x >= DEPTH returns 0.
  - Reads are fully functional while busy and return current contents: either a cleared 0 or a not-yet-cleared value.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 -> CLEAR, counter=0, busy=1 from the next cycle.
  - CLEAR: entry[counter] <= 0 and counter++ each cycle. After entry DEPTH-1 is cleared -> DONE. Total DEPTH cycles in CLEAR.
  - DONE: clr_done=1 and busy=0 for exactly one cycle, then IDLE. A clr_req during DONE is ignored.
- Simultaneous events:
  - clr_req and we in the same IDLE cycle: clear wins and the write is dropped.
  - clr_req while busy: ignored; there is no queueing or restart.
  - we while busy: ignored.
- Counter width is ADDR_W. Non-power-of-2 DEPTH terminates on counter==DEPTH-1; there is no wrap into unused codes.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first forwarding. When an accepted write (we=1, busy=0, in range) targets raddr_x in the same cycle, the next rdata_x = wdata. Both ports forward independently.
- Undefined: read-old-data as above. Bypass never applies to clear-engine writes.

Decomposition:
- Shared package regfile_pkg holds:
  - state enum (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2)
  - default WIDTH/DEPTH localparams
- One sub-module is natural: regfile_clear_fsm. It owns the state, counter, busy and clr_done, and outputs clr_we/clr_addr to the storage core.
- Storage array and read muxes stay in register_file.

Test Plan:
- Reset and basic write/read:
  - Stimulus: rst_n low then high; write 0x939A to addr 3; read A=3, B=0 next cycle.
  - Required: rdata_a=0x939A, rdata_b=0x0000, one cycle after the read address is applied.
- Dual-port independence: write 0xFFFF@1 and 0xCED8@6, then raddr_a=6, raddr_b=1 -> rdata_a=0xCED8, rdata_b=0xFFFF.
- Read-during-write: addr 2 holds 0x1111; write 0x2222@2 while raddr_a=2.
  - Macro off -> rdata_a=0x1111, then 0x2222 the following cycle.
  - Macro on -> rdata_a=0x2222 immediately.
- Clear sequence:
  - Stimulus: fill all 8 entries with nonzero values; pulse clr_req.
  - Required: busy high for exactly 8 cycles; clr_done pulses on the 9th; all entries read 0 afterwards.
  - Also: raddr=7 read mid-clear returns the old value until the counter passes 7.
- Collisions:
  - clr_req and we=1 (0xABCD@4) in the same cycle: entry 4 reads 0 after the clear.
  - we=1 during busy: has no effect.
  - Second clr_req during busy: busy length stays 8.
- Reset mid-clear and out-of-range access:
  - Reset mid-clear: deassert rst_n 3 cycles into the clear -> busy=0, clr_done never pulses, all entries 0.
  - Out-of-range (DEPTH=6): write to addr 7 is ignored; read of addr 7 returns 0.
